// File: rtl/irq_controller.sv
// irq_controller: synchronized, edge-latched, fixed-priority interrupt delivery to a PicoRV32 irq/eoi port.
// Define IRQC_STATS_EN to add a saturating 16-bit delivery counter at register address 3.
module irq_controller #(
  parameter int NUM_SRC  = 8,
  parameter int IRQ_BASE = 3
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NUM_SRC-1:0] i_src_irq,
  input  logic               i_reg_wr,
  input  logic               i_reg_rd,
  input  logic [1:0]         i_reg_addr,
  input  logic [31:0]        i_reg_wdata,
  output logic [31:0]        o_reg_rdata,
  output logic [31:0]        o_cpu_irq,
  input  logic [31:0]        i_cpu_eoi
);
  typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_t;
  state_t r_state, w_state_nx;
  logic [NUM_SRC-1:0] r_s1, r_s2, r_s3, r_en, r_pend;
  logic [NUM_SRC-1:0] w_rise, w_w1c, w_en_nx, w_keep, w_req, w_one, w_clr;
  logic [4:0] r_id, w_sel;
  logic [31:0] w_bit, w_status, w_cnt, w_rd_val;
  logic w_eoi, w_deliver, w_busy, w_unused;
  assign w_unused = ^i_reg_wdata;
  assign w_rise = r_s2 & ~r_s3;
  assign w_w1c = (i_reg_wr && i_reg_addr == 2'd1) ? i_reg_wdata[NUM_SRC-1:0] : '0;
  assign w_en_nx = (i_reg_wr && i_reg_addr == 2'd0) ? i_reg_wdata[NUM_SRC-1:0] : r_en;
  // pending as it will stand after this edge, ignoring the eoi clear; used to detect withdrawal
  assign w_keep = (r_pend & ~w_w1c) | w_rise;
  assign w_req = r_pend & r_en;
  assign w_one = NUM_SRC'(1) << r_id;
  assign w_bit = 32'd1 << (5'(IRQ_BASE) + r_id);
  assign w_eoi = |(i_cpu_eoi & w_bit);
  assign w_deliver = (r_state == ASSERT) && w_eoi;
  assign w_clr = w_deliver ? w_one : '0;
  assign w_busy = r_state != IDLE;
  assign w_status = {w_busy, 26'd0, w_busy ? r_id : 5'd0};
  assign o_cpu_irq = (r_state == ASSERT) ? w_bit : '0;
  assign w_rd_val = i_reg_addr == 2'd0 ? 32'(r_en) :
                    i_reg_addr == 2'd1 ? 32'(r_pend) :
                    i_reg_addr == 2'd2 ? w_status : w_cnt;
  always_comb begin
    w_sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (w_req[i]) w_sel = 5'(i);
  end
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    w_state_nx = |w_req ? ASSERT : IDLE;
      ASSERT:  w_state_nx = w_eoi ? SERVICE : (|(w_keep & w_en_nx & w_one) ? ASSERT : IDLE);
      SERVICE: w_state_nx = w_eoi ? SERVICE : IDLE;
      default: w_state_nx = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) r_state <= IDLE;
    else r_state <= w_state_nx;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
      r_en <= '0;
      r_pend <= '0;
      r_id <= '0;
      o_reg_rdata <= '0;
    end else begin
      r_s1 <= i_src_irq;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      r_en <= w_en_nx;
      r_pend <= (r_pend & ~w_w1c & ~w_clr) | w_rise;
      if (r_state == IDLE && |w_req) r_id <= w_sel;
      if (i_reg_rd) o_reg_rdata <= w_rd_val;
    end
  end
`ifdef IRQC_STATS_EN
  logic [15:0] r_cnt;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) r_cnt <= '0;
    else if (i_reg_wr && i_reg_addr == 2'd3) r_cnt <= '0;
    else if (w_deliver && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
  assign w_cnt = {16'd0, r_cnt};
`else
  assign w_cnt = '0;
`endif
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: vector table, directed corner sequences and random traffic against a spec-level model.
module tb_irq_controller;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [7:0] src_v = 0;
  logic wr = 0, rd = 0;
  logic [1:0] addr = 0;
  logic [31:0] wdata = 0, eoi_v = 0;
  logic [31:0] rdata, irq;
  irq_controller dut (
    .i_clk(clk), .i_reset(rst), .i_src_irq(src_v), .i_reg_wr(wr), .i_reg_rd(rd),
    .i_reg_addr(addr), .i_reg_wdata(wdata), .o_reg_rdata(rdata), .o_cpu_irq(irq), .i_cpu_eoi(eoi_v)
  );
  int checks = 0, errors = 0;
  logic [7:0] m_en, m_pend;
  logic [7:0] hist [3];
  bit m_off, m_hnd;
  int m_id, m_cnt;
  logic [31:0] m_rdata;
  typedef struct {
    logic [7:0] src;
    logic wr, rd;
    logic [1:0] addr;
    logic [31:0] wdata, eoi, exp_irq, exp_rdata;
  } vec_t;
  vec_t tv [20];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic m_reset();
    m_en = 0; m_pend = 0; m_off = 0; m_hnd = 0; m_id = 0; m_cnt = 0; m_rdata = 0;
    for (int i = 0; i < 3; i++) hist[i] = 0;
  endtask
  function automatic logic [31:0] m_reg(input logic [1:0] a);
    case (a)
      2'd0: return {24'd0, m_en};
      2'd1: return {24'd0, m_pend};
      2'd2: return (m_off || m_hnd) ? (32'h8000_0000 | 32'(m_id)) : 32'd0;
`ifdef IRQC_STATS_EN
      default: return 32'(m_cnt);
`else
      default: return 32'd0;
`endif
    endcase
  endfunction
  task automatic m_tick(input logic w, input logic r, input logic [1:0] a, input logic [31:0] d,
                        input logic [7:0] s, input logic [31:0] e);
    logic [7:0] rise, w1c, en_nx, keep, pend_nx;
    bit ev, inc;
    int lo;
    rise = hist[1] & ~hist[2];
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = s;
    if (r) m_rdata = m_reg(a);
    w1c = (w && a == 2'd1) ? d[7:0] : 8'd0;
    en_nx = (w && a == 2'd0) ? d[7:0] : m_en;
    keep = (m_pend & ~w1c) | rise;
    pend_nx = keep;
    ev = e[3 + m_id];
    inc = 0;
    if (!m_off && !m_hnd) begin
      lo = -1;
      for (int i = 7; i >= 0; i--) if (m_pend[i] && m_en[i]) lo = i;
      if (lo >= 0) begin m_id = lo; m_off = 1; end
    end else if (m_off) begin
      if (ev) begin
        pend_nx[m_id] = rise[m_id];
        m_off = 0; m_hnd = 1; inc = 1;
      end else if (!(keep[m_id] && en_nx[m_id])) m_off = 0;
    end else if (!ev) m_hnd = 0;
    if (w && a == 2'd3) m_cnt = 0;
    else if (inc && m_cnt < 65535) m_cnt++;
    m_pend = pend_nx;
    m_en = en_nx;
  endtask
  task automatic step(input logic w, input logic r, input logic [1:0] a, input logic [31:0] d);
    wr = w; rd = r; addr = a; wdata = d;
    @(posedge clk);
    m_tick(w, r, a, d, src_v, eoi_v);
    #1;
    chk("cpu_irq", irq, m_off ? (32'd1 << (3 + m_id)) : 32'd0);
    chk("reg_rdata", rdata, m_rdata);
    wr = 0; rd = 0;
  endtask
  task automatic wait_irq(input logic [31:0] exp, input string name);
    for (int n = 0; n < 8 && irq !== exp; n++) step(0, 0, 0, 0);
    chk(name, irq, exp);
  endtask
  task automatic do_reset();
    #2 rst = 1;
    #1;
    chk("rst_irq", irq, 0);
    chk("rst_rdata", rdata, 0);
    m_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask
  initial begin
    tv[0]  = '{8'h00, 1, 0, 2'd0, 32'h01, 32'h00, 32'h00, 32'h00};
    tv[1]  = '{8'h01, 0, 0, 2'd0, 32'h00, 32'h00, 32'h00, 32'h00};
    tv[2]  = '{8'h01, 0, 0, 2'd0, 32'h00, 32'h00, 32'h00, 32'h00};
    tv[3]  = '{8'h01, 0, 0, 2'd0, 32'h00, 32'h00, 32'h00, 32'h00};
    tv[4]  = '{8'h01, 0, 1, 2'd1, 32'h00, 32'h00, 32'h08, 32'h01};
    tv[5]  = '{8'h01, 0, 0, 2'd0, 32'h00, 32'h08, 32'h00, 32'h01};
    tv[6]  = '{8'h01, 0, 1, 2'd1, 32'h00, 32'h08, 32'h00, 32'h00};
    tv[7]  = '{8'h00, 0, 1, 2'd2, 32'h00, 32'h08, 32'h00, 32'h8000_0000};
    tv[8]  = '{8'h00, 0, 0, 2'd0, 32'h00, 32'h00, 32'h00, 32'h8000_0000};
    tv[9]  = '{8'h00, 0, 1, 2'd2, 32'h00, 32'h00, 32'h00, 32'h00};
    tv[10] = '{8'h00, 1, 0, 2'd0, 32'h00, 32'h00, 32'h00, 32'h00};
    tv[11] = '{8'h10, 0, 0, 2'd0, 32'h00, 32'h00, 32'h00, 32'h00};
    tv[12] = '{8'h10, 0, 0, 2'd0, 32'h00, 32'h00, 32'h00, 32'h00};
    tv[13] = '{8'h10, 0, 0, 2'd0, 32'h00, 32'h00, 32'h00, 32'h00};
    tv[14] = '{8'h10, 0, 1, 2'd1, 32'h00, 32'h00, 32'h00, 32'h10};
    tv[15] = '{8'h10, 1, 0, 2'd0, 32'h10, 32'h00, 32'h00, 32'h10};
    tv[16] = '{8'h10, 0, 0, 2'd0, 32'h00, 32'h00, 32'h80, 32'h10};
    tv[17] = '{8'h10, 0, 0, 2'd0, 32'h00, 32'h80, 32'h00, 32'h10};
    tv[18] = '{8'h10, 0, 0, 2'd0, 32'h00, 32'h00, 32'h00, 32'h10};
    tv[19] = '{8'h10, 0, 1, 2'd2, 32'h00, 32'h00, 32'h00, 32'h00};
    m_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset_irq", irq, 0);
    chk("reset_rdata", rdata, 0);
    rst = 0;
    for (int i = 0; i < 20; i++) begin
      src_v = tv[i].src;
      eoi_v = tv[i].eoi;
      step(tv[i].wr, tv[i].rd, tv[i].addr, tv[i].wdata);
      chk($sformatf("vec%0d_irq", i), irq, tv[i].exp_irq);
      chk($sformatf("vec%0d_rdata", i), rdata, tv[i].exp_rdata);
    end
    src_v = 0; eoi_v = 0;
    step(1, 0, 0, 32'hFF);
    src_v = 8'h24;
    wait_irq(32'h20, "prio_first");
    eoi_v = 32'h20; step(0, 0, 0, 0);
    eoi_v = 0; step(0, 0, 0, 0);
    wait_irq(32'h100, "prio_second");
    eoi_v = 32'h100; step(0, 0, 0, 0);
    eoi_v = 0; step(0, 0, 0, 0);
    src_v = 8'h02;
    wait_irq(32'h10, "wd_assert");
    step(1, 0, 1, 32'h02);
    chk("wd_drop", irq, 0);
    step(0, 1, 2, 0);
    chk("wd_status", rdata, 0);
    step(1, 0, 0, 0);
    src_v = 8'h0A;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 1, 32'h08);
    step(0, 1, 1, 0);
    chk("set_wins", rdata, 32'h08);
    src_v = 0;
    step(1, 0, 1, 32'hFF);
    step(1, 0, 0, 32'h01);
    src_v = 8'h01;
    wait_irq(32'h08, "svc_assert");
    eoi_v = 32'h08; step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    do_reset();
    eoi_v = 0; src_v = 0;
    step(0, 1, 0, 0); chk("rst_enable", rdata, 0);
    step(0, 1, 1, 0); chk("rst_pending", rdata, 0);
    step(0, 1, 2, 0); chk("rst_status", rdata, 0);
    step(1, 0, 0, 32'h01);
    src_v = 8'h01;
    wait_irq(32'h08, "re_first");
    eoi_v = 32'h08; step(0, 0, 0, 0);
    src_v = 0;
    repeat (3) step(0, 0, 0, 0);
    src_v = 8'h01;
    repeat (4) step(0, 0, 0, 0);
    eoi_v = 0;
    wait_irq(32'h08, "re_second");
    eoi_v = 32'h08; step(0, 0, 0, 0);
    eoi_v = 0; step(0, 0, 0, 0);
`ifdef IRQC_STATS_EN
    step(0, 1, 3, 0); chk("count2", rdata, 2);
    step(1, 0, 3, 0);
    step(0, 1, 3, 0); chk("count_clr", rdata, 0);
`endif
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) src_v = src_v ^ 8'($urandom);
      if ($urandom_range(0, 3) == 0) eoi_v = $urandom & $urandom;
      if (irq != 0 && $urandom_range(0, 2) == 0) eoi_v = eoi_v | irq;
      if ($urandom_range(0, 599) == 0) do_reset();
      else step($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, 2'($urandom),
                $urandom_range(0, 3) == 0 ? $urandom : 32'hFF);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Interrupt controller between NUM_SRC external interrupt sources and the PicoRV32 core's 32-bit irq/eoi interface in the system top level.
- Synchronizes and edge-detects the sources, latches them as pending, and masks them with a software-writable enable register.
- Delivers one interrupt at a time to the core using fixed priority (lowest index wins) and follows the core's eoi handshake.
- Exposes enable, pending and status through a small register port on the system bus.

Parameters:
- NUM_SRC, 8: number of external interrupt sources; legal range 1..16.
- IRQ_BASE, 3: first cpu_irq bit used. Bits 0..2 stay reserved for the core's timer, ebreak and bus-error interrupts. IRQ_BASE+NUM_SRC must be at most 32.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- src_irq  in  NUM_SRC  raw interrupt sources, asynchronous to clk.
- reg_wr  in  1  register write strobe, one cycle.
- reg_rd  in  1  register read strobe, one cycle.
- reg_addr  in  2  register select.
- reg_wdata  in  32  write data.
- reg_rdata  out  32  read data, registered.
- cpu_irq  out  32  to core irq input.
- cpu_eoi  in  32  from core eoi output.

Behaviour:
- Reset values: all outputs 0, ENABLE=0, PENDING=0, FSM=IDLE, synchronizers 0. Reset is asynchronous. Asserting it mid-service drops cpu_irq in the same cycle and discards the in-flight interrupt.
- Input path: 2-flop synchronizer per source, then rising-edge detect.
  - An edge sets PENDING[i] on the next clk. Total latency from a src rise to PENDING set is 3 clks.
  - Disabled sources still latch pending.
- Register map (reg_rdata is valid the cycle after reg_rd and holds until the next read):
  - Address 0, ENABLE: RW, bits [NUM_SRC-1:0].
  - Address 1, PENDING: read returns pending; write-1-to-clear.
  - Address 2, STATUS: bit31 = busy (FSM not IDLE), bits[4:0] = active source id.
  - Address 3, COUNT: see Optional Feature.
  - Unused bits read 0.
- Simultaneous reg_rd and reg_wr: the write takes effect and the read returns the pre-write value.
- Edge on bit i in the same cycle as a W1C of bit i: the set wins.
- FSM states:
  - IDLE: if (PENDING & ENABLE) != 0, latch id = lowest set index and go to ASSERT.
  - ASSERT: drive cpu_irq[IRQ_BASE+id]=1 (only one bit is ever high). When cpu_eoi[IRQ_BASE+id]=1 (handler entered): clear PENDING[id], drop cpu_irq, go to SERVICE.
  - SERVICE: wait for cpu_eoi[IRQ_BASE+id]=0 (retirq), then go to IDLE.
  - IDLE re-arbitrates on the next cycle, so there is one dead cycle between back-to-back deliveries.
- Disabling or W1C-clearing the active source while in ASSERT withdraws it: drop cpu_irq and return to IDLE.
- A new edge on the active source during SERVICE re-sets PENDING. That source is delivered again after SERVICE ends.
- Eoi bits other than the active one are ignored. cpu_irq bits outside the IRQ_BASE..IRQ_BASE+NUM_SRC-1 range are tied to 0.

Optional Feature:
- IRQC_STATS_EN defined:
  - Adds a 16-bit delivery counter that increments on each ASSERT->SERVICE transition and saturates at 0xFFFF.
  - Readable at address 3; any write to address 3 clears it.
  - A write clear in the same cycle as an increment leaves the counter at 0.
  - Reset value 0.
- IRQC_STATS_EN undefined: address 3 reads 0, writes are ignored, no counter logic.

Test Plan:
- ENABLE=0x01; pulse src_irq[0] for 10 clks -> PENDING=0x01 after 3 clks. Next cycle cpu_irq=0x00000008. Core eoi[3] rises -> cpu_irq=0, PENDING=0. eoi falls -> STATUS bit31=0.
- ENABLE=0xFF; raise src 5 and src 2 in the same cycle -> src 2 delivered first (cpu_irq=0x20). After its eoi cycle, src 5 delivered (cpu_irq=0x100).
- ENABLE=0x00; pulse src 4 -> PENDING=0x10, cpu_irq stays 0. Write ENABLE=0x10 -> cpu_irq=0x80 two clks later.
- In ASSERT for src 1, write PENDING=0x02 -> cpu_irq=0 next cycle, FSM IDLE. Same-cycle edge+W1C on src 3 -> PENDING[3]=1.
- Assert reset while in SERVICE -> cpu_irq, ENABLE, PENDING and STATUS read 0 after release. With IRQC_STATS_EN: 3 deliveries -> COUNT=3; write addr 3 -> COUNT=0.
- Edge on src 0 during its own SERVICE -> delivered a second time after eoi falls; with IRQC_STATS_EN, COUNT=2.
